// File: rtl/data_counter_pkg.sv
// Shared constants, types and range helper for the saturating data_counter.
package data_counter_pkg;

  localparam string SIGNED_YES = "Yes";
  localparam string SIGNED_NO  = "No";

  localparam int MIN_SIZE = 2;
  localparam int MAX_SIZE = 32;

  // Synchroniser depth plus the edge-detect flop.
  localparam int SYNC_STAGES = 3;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2
  } step_e;

  typedef struct packed {
    logic [31:0] min_val;
    logic [31:0] max_val;
  } limits_t;

  // Only the low `size` bits of each field are meaningful.
  function automatic limits_t limits(input int size, input string mode);
    limits_t     lim;
    logic [32:0] span;
    span = 33'd1 << size;
    if (mode == SIGNED_YES) begin
      // 2^(size-1) as a size-bit pattern is the most negative value.
      lim.min_val = 32'(span >> 1);
      lim.max_val = 32'((span >> 1) - 33'd1);
    end else begin
      lim.min_val = '0;
      lim.max_val = 32'(span - 33'd1);
    end
    return lim;
  endfunction

endpackage

// File: rtl/data_counter_edge_pulse.sv
// Synchronises an asynchronous request and emits one pulse per low->high edge.
module edge_pulse
  import data_counter_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic In,
  output logic Pulse
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] fill_reg;

  // fill_reg tracks which stages hold a real sample since reset; the zeros
  // loaded by reset must not look like a low level preceding a held input.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_reg <= '0;
      fill_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], In};
      fill_reg <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign Pulse = sync_reg[SYNC_STAGES-2] & ~sync_reg[SYNC_STAGES-1]
               & fill_reg[SYNC_STAGES-1];

endmodule

// File: rtl/data_counter.sv
// Saturating up/down counter fed by edge-detected Up/Down requests.
module data_counter
  import data_counter_pkg::*;
#(
  parameter int    Size   = 3,
  parameter string Signed = "Yes"
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Up,
  input  logic            Down,
  output logic [Size-1:0] Data
);

  generate
    if (Size < MIN_SIZE || Size > MAX_SIZE) begin : g_bad_size
      $error("data_counter: Size must be in 2..32");
    end
    if (Signed != SIGNED_YES && Signed != SIGNED_NO) begin : g_bad_signed
      $error("data_counter: Signed must be \"Yes\" or \"No\"");
    end
  endgenerate

  localparam limits_t         LIM       = limits(Size, Signed);
  localparam logic [Size-1:0] MIN_V     = LIM.min_val[Size-1:0];
  localparam logic [Size-1:0] MAX_V     = LIM.max_val[Size-1:0];
  localparam bit              IS_SIGNED = (Signed == SIGNED_YES);

  logic            up_pulse;
  logic            down_pulse;
  logic            at_max;
  logic            at_min;
  step_e           step;
  logic [Size-1:0] data_reg;
  logic [Size-1:0] data_next;

  edge_pulse u_up_pulse (
    .Clock (Clock),
    .Reset (Reset),
    .In    (Up),
    .Pulse (up_pulse)
  );

  edge_pulse u_down_pulse (
    .Clock (Clock),
    .Reset (Reset),
    .In    (Down),
    .Pulse (down_pulse)
  );

  always_comb begin
    at_max = 1'b0;
    at_min = 1'b0;
    if (IS_SIGNED) begin
      at_max = $signed(data_reg) >= $signed(MAX_V);
      at_min = $signed(data_reg) <= $signed(MIN_V);
    end else begin
      at_max = data_reg >= MAX_V;
      at_min = data_reg <= MIN_V;
    end
  end

  // Simultaneous requests cancel each other.
  always_comb begin
    step = STEP_HOLD;
    if (up_pulse && !down_pulse && !at_max) begin
      step = STEP_INC;
    end else if (down_pulse && !up_pulse && !at_min) begin
      step = STEP_DEC;
    end
  end

  always_comb begin
    data_next = data_reg;
    case (step)
      STEP_INC: data_next = data_reg + 1'b1;
      STEP_DEC: data_next = data_reg - 1'b1;
      default:  data_next = data_reg;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      data_reg <= '0;
    end else begin
      data_reg <= data_next;
    end
  end

  assign Data = data_reg;

endmodule

// File: tb/tb_data_counter.sv
// Directed bench for data_counter: signed and unsigned 3-bit instances.
module tb_data_counter;

  logic       clk;
  logic       rst;
  logic       up;
  logic       down;
  logic [2:0] data_s;
  logic [2:0] data_u;

  int checks;
  int failures;

  data_counter #(.Size(3), .Signed("Yes")) dut_s (
    .Clock (clk),
    .Reset (rst),
    .Up    (up),
    .Down  (down),
    .Data  (data_s)
  );

  data_counter #(.Size(3), .Signed("No")) dut_u (
    .Clock (clk),
    .Reset (rst),
    .Up    (up),
    .Down  (down),
    .Data  (data_u)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic test_reset;
    @(negedge clk);
    up   = 1'b0;
    down = 1'b1;
    @(negedge clk);
    checks++;
    if (data_s !== 3'd0) begin
      failures++;
      $display("FAIL reset_signed: got %b expected %b", data_s, 3'd0);
    end
    checks++;
    if (data_u !== 3'd0) begin
      failures++;
      $display("FAIL reset_unsigned: got %b expected %b", data_u, 3'd0);
    end
    rst  = 1'b0;
    down = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (data_s !== 3'd0) begin
      failures++;
      $display("FAIL reset_idle: got %b expected %b", data_s, 3'd0);
    end
    $display("test_reset done: data_s=%b data_u=%b", data_s, data_u);
  endtask

  task automatic test_up_saturate;
    logic [2:0] exp_v [9] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
    logic [2:0] prev;
    prev = 3'd0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      up = 1'b1;
      @(negedge clk);
      up = 1'b0;
      checks++;
      if (data_s !== prev) begin
        failures++;
        $display("FAIL up_lat_n[%0d]: got %b expected %b", i, data_s, prev);
      end
      @(negedge clk);
      checks++;
      if (data_s !== prev) begin
        failures++;
        $display("FAIL up_lat_n1[%0d]: got %b expected %b", i, data_s, prev);
      end
      @(negedge clk);
      checks++;
      if (data_s !== exp_v[i]) begin
        failures++;
        $display("FAIL up_step[%0d]: got %b expected %b", i, data_s, exp_v[i]);
      end
      $display("up pulse %0d: data_s=%b", i, data_s);
      prev = exp_v[i];
    end
  endtask

  task automatic test_down_saturate;
    logic [2:0] exp_v [9] = '{3'd2, 3'd1, 3'd0, 3'b111, 3'b110, 3'b101, 3'b100, 3'b100, 3'b100};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      down = 1'b1;
      @(negedge clk);
      down = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (data_s !== exp_v[i]) begin
        failures++;
        $display("FAIL down_step[%0d]: got %b expected %b", i, data_s, exp_v[i]);
      end
      $display("down pulse %0d: data_s=%b", i, data_s);
    end
  endtask

  task automatic test_hold_high;
    @(negedge clk);
    up = 1'b1;
    repeat (10) @(negedge clk);
    up = 1'b0;
    checks++;
    if (data_s !== 3'b101) begin
      failures++;
      $display("FAIL hold_high: got %b expected %b", data_s, 3'b101);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (data_s !== 3'b101) begin
      failures++;
      $display("FAIL hold_release: got %b expected %b", data_s, 3'b101);
    end
    $display("hold high: data_s=%b", data_s);
  endtask

  task automatic test_both;
    @(negedge clk);
    up   = 1'b1;
    down = 1'b1;
    @(negedge clk);
    up   = 1'b0;
    down = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (data_s !== 3'b101) begin
      failures++;
      $display("FAIL both_signed: got %b expected %b", data_s, 3'b101);
    end
    // Unsigned copy went 0->7, 7->0, then +1 from the held Up.
    checks++;
    if (data_u !== 3'd1) begin
      failures++;
      $display("FAIL both_unsigned: got %b expected %b", data_u, 3'd1);
    end
    $display("both edges: data_s=%b data_u=%b", data_s, data_u);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    up = 1'b1;
    @(negedge clk);
    up  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (data_s !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid: got %b expected %b", data_s, 3'd0);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (data_s !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid_late: got %b expected %b", data_s, 3'd0);
    end
    @(negedge clk);
    up = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (data_s !== 3'd1) begin
      failures++;
      $display("FAIL pre_held_step: got %b expected %b", data_s, 3'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (data_s !== 3'd0) begin
      failures++;
      $display("FAIL held_after_reset: got %b expected %b", data_s, 3'd0);
    end
    up = 1'b0;
    repeat (3) @(negedge clk);
    up = 1'b1;
    @(negedge clk);
    up = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (data_s !== 3'd1) begin
      failures++;
      $display("FAIL step_after_reset: got %b expected %b", data_s, 3'd1);
    end
    $display("reset mid-operation: data_s=%b", data_s);
  endtask

  task automatic test_unsigned;
    logic [2:0] up_v [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
    logic [2:0] dn_v [9] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (data_u !== 3'd0) begin
      failures++;
      $display("FAIL unsigned_reset: got %b expected %b", data_u, 3'd0);
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      up = 1'b1;
      @(negedge clk);
      up = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (data_u !== up_v[i]) begin
        failures++;
        $display("FAIL unsigned_up[%0d]: got %b expected %b", i, data_u, up_v[i]);
      end
      $display("unsigned up pulse %0d: data_u=%b", i, data_u);
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      down = 1'b1;
      @(negedge clk);
      down = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (data_u !== dn_v[i]) begin
        failures++;
        $display("FAIL unsigned_down[%0d]: got %b expected %b", i, data_u, dn_v[i]);
      end
      $display("unsigned down pulse %0d: data_u=%b", i, data_u);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    up       = 1'b1;
    down     = 1'b0;
    test_reset();
    test_up_saturate();
    test_down_saturate();
    test_hold_high();
    test_both();
    test_reset_mid();
    test_unsigned();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
